// File: rtl/image_pixel_fetch.sv
// Overlays one stored picture from an external synchronous ROM on the VGA stream.
// Three-stage pipeline: address generation, ROM access, colour compose.
module image_pixel_fetch #(
    parameter int           X_POS      = 100,
    parameter int           Y_POS      = 100,
    parameter int           IMG_W      = 128,
    parameter int           IMG_H      = 96,
    parameter int           ADDR_W     = 14,
    parameter bit           TRANSP_EN  = 1'b1,
    parameter logic [11:0]  TRANSP_RGB = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       hcount_in,
    input  logic [10:0]       vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    output logic [ADDR_W-1:0] pixel_addr,
    input  logic [11:0]       rgb_pixel,
    output logic [10:0]       hcount_out,
    output logic [10:0]       vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out
);

    // Bounds held one bit wider than the counters so X_POS+IMG_W may reach 2048.
    localparam logic [11:0] X_LO  = 12'(X_POS);
    localparam logic [11:0] X_HI  = 12'(X_POS + IMG_W);
    localparam logic [11:0] Y_LO  = 12'(Y_POS);
    localparam logic [11:0] Y_HI  = 12'(Y_POS + IMG_H);
    localparam logic [10:0] X_OFF = 11'(X_POS);
    localparam logic [10:0] Y_OFF = 11'(Y_POS);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_rect;
    } pipe_t;

    pipe_t             in_s;
    pipe_t             d1_r;
    pipe_t             d2_r;
    logic [10:0]       col_s;
    logic [10:0]       row_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] pixel_addr_r;
    logic [11:0]       rgb_sel_s;
    logic              rom_transp_s;

    logic [10:0]       hcount_r;
    logic [10:0]       vcount_r;
    logic              hsync_r;
    logic              vsync_r;
    logic              hblnk_r;
    logic              vblnk_r;
    logic [11:0]       rgb_r;

    // Rectangle test and ROM address; offsets are zeroed outside so nothing underflows.
    always_comb begin
        in_s.hcount  = hcount_in;
        in_s.vcount  = vcount_in;
        in_s.hsync   = hsync_in;
        in_s.vsync   = vsync_in;
        in_s.hblnk   = hblnk_in;
        in_s.vblnk   = vblnk_in;
        in_s.rgb     = rgb_in;
        in_s.in_rect = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                       ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI) &&
                       !hblnk_in && !vblnk_in;
        if (in_s.in_rect) begin
            col_s = hcount_in - X_OFF;
            row_s = vcount_in - Y_OFF;
        end else begin
            col_s = 11'd0;
            row_s = 11'd0;
        end
        addr_s = ADDR_W'((32'(row_s) * 32'(IMG_W)) + 32'(col_s));
    end

    // Stage 1: register address, timing, background and rectangle flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_r         <= '0;
            pixel_addr_r <= '0;
        end else begin
            d1_r         <= in_s;
            pixel_addr_r <= addr_s;
        end
    end

    // Stage 2: delay alongside the ROM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d2_r <= '0;
        end else begin
            d2_r <= d1_r;
        end
    end

    // Colour select: ROM pixel inside the rectangle unless it matches the key.
    always_comb begin
        rom_transp_s = TRANSP_EN && (rgb_pixel == TRANSP_RGB);
        if (d2_r.in_rect && !rom_transp_s) begin
            rgb_sel_s = rgb_pixel;
        end else begin
            rgb_sel_s = d2_r.rgb;
        end
    end

    // Stage 3: output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_r <= 11'd0;
            vcount_r <= 11'd0;
            hsync_r  <= 1'b0;
            vsync_r  <= 1'b0;
            hblnk_r  <= 1'b0;
            vblnk_r  <= 1'b0;
            rgb_r    <= 12'd0;
        end else begin
            hcount_r <= d2_r.hcount;
            vcount_r <= d2_r.vcount;
            hsync_r  <= d2_r.hsync;
            vsync_r  <= d2_r.vsync;
            hblnk_r  <= d2_r.hblnk;
            vblnk_r  <= d2_r.vblnk;
            rgb_r    <= rgb_sel_s;
        end
    end

    assign pixel_addr = pixel_addr_r;
    assign hcount_out = hcount_r;
    assign vcount_out = vcount_r;
    assign hsync_out  = hsync_r;
    assign vsync_out  = vsync_r;
    assign hblnk_out  = hblnk_r;
    assign vblnk_out  = vblnk_r;
    assign rgb_out    = rgb_r;

endmodule

// File: tb/tb_image_pixel_fetch.sv
// Randomized bench for image_pixel_fetch: two instances (colour key on/off)
// checked against a pixel-level reference model with a 3-deep history queue.
module tb_image_pixel_fetch;

    localparam int XP = 100;
    localparam int YP = 100;
    localparam int IW = 128;
    localparam int IH = 96;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = 11'd0;
    logic [10:0] vcount_in = 11'd0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = 12'd0;
    logic        rom_force = 1'b0;

    logic [13:0] addr_a, addr_b;
    logic [11:0] pix_a, pix_b, rgb_a, rgb_b;
    logic [10:0] hc_a, vc_a, hc_b, vc_b;
    logic        hs_a, vs_a, hb_a, vb_a, hs_b, vs_b, hb_b, vb_b;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 clk = ~clk;

    image_pixel_fetch u_dut_key (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .pixel_addr(addr_a), .rgb_pixel(pix_a),
        .hcount_out(hc_a), .vcount_out(vc_a), .hsync_out(hs_a), .vsync_out(vs_a),
        .hblnk_out(hb_a), .vblnk_out(vb_a), .rgb_out(rgb_a)
    );

    image_pixel_fetch #(.TRANSP_EN(1'b0)) u_dut_nokey (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .pixel_addr(addr_b), .rgb_pixel(pix_b),
        .hcount_out(hc_b), .vcount_out(vc_b), .hsync_out(hs_b), .vsync_out(vs_b),
        .hblnk_out(hb_b), .vblnk_out(vb_b), .rgb_out(rgb_b)
    );

    // Image ROMs: data is the low 12 address bits, or the colour key when forced.
    always_ff @(posedge clk) begin
        pix_a <= rom_force ? 12'hF0F : addr_a[11:0];
        pix_b <= rom_force ? 12'hF0F : addr_b[11:0];
    end

    typedef struct {
        int h;
        int v;
        bit hs, vs, hb, vb;
        int rgb;
        bit force_rom;
    } rec_t;

    rec_t hist[$];

    function automatic bit ref_inside(rec_t r);
        return (r.h >= XP) && (r.h < XP + IW) && (r.v >= YP) && (r.v < YP + IH) && !r.hb && !r.vb;
    endfunction

    function automatic int ref_addr(rec_t r);
        return ref_inside(r) ? ((r.v - YP) * IW + (r.h - XP)) : 0;
    endfunction

    function automatic int ref_rgb(rec_t r, bit key_en);
        int rom;
        if (!ref_inside(r)) return r.rgb;
        rom = r.force_rom ? 32'h0F0F : (ref_addr(r) % 4096);
        if (key_en && rom == 32'h0F0F) return r.rgb;
        return rom;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            if (n_mismatch <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic prime_history();
        rec_t z;
        z = '{h: 0, v: 0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: 0, force_rom: 1'b0};
        hist.delete();
        hist.push_back(z);
        hist.push_back(z);
    endtask

    task automatic step(input int h, input int v, input bit hs, input bit vs,
                        input bit hb, input bit vb, input int rgb);
        rec_t r;
        rec_t e;
        r = '{h: h, v: v, hs: hs, vs: vs, hb: hb, vb: vb, rgb: rgb, force_rom: rom_force};
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = 12'(rgb);
        @(posedge clk);
        hist.push_back(r);
        #1;
        check_eq("pixel_addr", 32'(addr_a), 32'(ref_addr(r)));
        check_eq("pixel_addr_nokey", 32'(addr_b), 32'(ref_addr(r)));
        e = hist.pop_front();
        check_eq("hcount_out", 32'(hc_a), 32'(e.h));
        check_eq("vcount_out", 32'(vc_a), 32'(e.v));
        check_eq("sync_blank_out", {28'd0, hs_a, vs_a, hb_a, vb_a}, {28'd0, e.hs, e.vs, e.hb, e.vb});
        check_eq("rgb_out", 32'(rgb_a), 32'(ref_rgb(e, 1'b1)));
        check_eq("rgb_out_nokey", 32'(rgb_b), 32'(ref_rgb(e, 1'b0)));
        check_eq("timing_nokey", {6'd0, hc_b, vc_b, hs_b, vs_b, hb_b, vb_b},
                 {6'd0, 11'(e.h), 11'(e.v), e.hs, e.vs, e.hb, e.vb});
    endtask

    task automatic check_zero_outputs();
        check_eq("rst_pixel_addr", {18'd0, addr_a}, 32'd0);
        check_eq("rst_rgb_out", {20'd0, rgb_a}, 32'd0);
        check_eq("rst_timing_out", {6'd0, hc_a, vc_a, hs_a, vs_a, hb_a, vb_a}, 32'd0);
        check_eq("rst_rgb_out_nokey", {20'd0, rgb_b}, 32'd0);
    endtask

    // Assert reset between edges, check immediate clear, release away from an edge.
    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        check_zero_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs();
        #3;
        rst = 1'b0;
        prime_history();
    endtask

    task automatic set_force(input bit f);
        repeat (3) step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000);
        rom_force = f;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected run completion");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        pulse_reset();

        // Corners, edges just outside, blanking and the native colour-key address.
        step(100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5A5);
        step(227, 195, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5A5);
        step(99,  150, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0A0);
        step(228, 150, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0A0);
        step(150, 99,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0A0);
        step(150, 196, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0A0);
        step(150, 150, 1'b0, 1'b0, 1'b1, 1'b0, 32'h321);
        step(150, 150, 1'b0, 1'b0, 1'b0, 1'b1, 32'h321);
        step(150, 150, 1'b1, 1'b1, 1'b0, 1'b0, 32'h321);
        step(115, 130, 1'b0, 1'b0, 1'b0, 1'b0, 32'h123);
        step(101, 100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h777);
        step(100, 101, 1'b0, 1'b0, 1'b0, 1'b0, 32'h777);

        set_force(1'b1);
        step(150, 150, 1'b0, 1'b0, 1'b0, 1'b0, 32'h123);
        step(120, 110, 1'b0, 1'b0, 1'b0, 1'b0, 32'h123);
        step(99,  110, 1'b0, 1'b0, 1'b0, 1'b0, 32'h123);
        set_force(1'b0);

        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 150) set_force(~rom_force);
            step(int'($urandom_range(90, 240)), int'($urandom_range(90, 205)),
                 $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 4095)));
        end
        set_force(1'b0);

        // Window scan with raster timing and a reset mid-line.
        for (int v = 95; v <= 200; v++) begin
            for (int h = 80; h <= 260; h++) begin
                if (v == 140 && h == 170) pulse_reset();
                step(h, v, (h >= 250), (v >= 199), (h >= 245) || ($urandom_range(0, 31) == 0),
                     (v >= 198), int'($urandom_range(0, 4095)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
